// File: rtl/aes_pkg.sv
// Shared constants, types and helpers for the AES-128 key expansion block.
// NW is the total schedule length in 32-bit words: (NR+1)*NK.
package aes_pkg;

    localparam int NR = 10;
    localparam int NK = 4;
    localparam int NW = 44;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

    // Indices outside 1..10 never occur during expansion; return 0 for them.
    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        if (idx >= 4'd1 && idx <= 4'd10) begin
            return RCON[idx];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: one byte in, one substituted byte out.
// The table is stored as a packed constant, indexed directly by the input byte.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key expansion: one schedule word per cycle after start,
// with any completed round key readable combinationally by round number.
module aes_key_schedule #(
    parameter int NR = 10,
    parameter int NK = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic [3:0]   avail,
    input  logic [3:0]   rk_sel,
    output logic [127:0] rk_out
);

    import aes_pkg::*;

    // Only NR=10 / NK=4 is meaningful; the array size follows them anyway.
    localparam int NW_L = (NR + 1) * NK;

    ks_state_t   state_reg, state_next;
    logic [5:0]  i_reg, i_next;
    logic [3:0]  avail_reg, avail_next;
    word_t       w_reg [NW_L];

    logic        load_en;
    logic        expand_en;
    word_t       prev_word;
    word_t       back_word;
    word_t       rot_word;
    word_t       sub_word;
    word_t       temp_word;
    word_t       new_word;

    // ---------------- control FSM ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= IDLE;
            i_reg     <= 6'd4;
            avail_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            i_reg     <= i_next;
            avail_reg <= avail_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        i_next     = i_reg;
        avail_next = avail_reg;
        load_en    = 1'b0;
        expand_en  = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    load_en    = 1'b1;
                    i_next     = 6'd4;
                    avail_next = 4'd0;
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                expand_en = 1'b1;
                i_next    = i_reg + 6'd1;
                // Writing the last word of a round key completes round i/4.
                if (i_reg[1:0] == 2'd3) begin
                    avail_next = i_reg[5:2];
                end
                if (i_reg == 6'(NW_L - 1)) begin
                    i_next     = i_reg;
                    avail_next = 4'(NR);
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- word generation ----------------
    assign prev_word = w_reg[i_reg - 6'd1];
    assign back_word = w_reg[i_reg - 6'(NK)];
    assign rot_word  = {prev_word[23:0], prev_word[31:24]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (rot_word[8*gi +: 8]),
            .dout (sub_word[8*gi +: 8])
        );
    end

    always_comb begin
        temp_word = prev_word;
        if (i_reg[1:0] == 2'd0) begin
            temp_word = sub_word ^ {rcon_of(i_reg[5:2]), 24'h000000};
        end
        new_word = back_word ^ temp_word;
    end

    // ---------------- schedule storage ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < NW_L; k++) begin
                w_reg[k] <= '0;
            end
        end else if (load_en) begin
            for (int k = 0; k < NK; k++) begin
                w_reg[k] <= key_in[127 - 32*k -: 32];
            end
        end else if (expand_en) begin
            w_reg[i_reg] <= new_word;
        end
    end

    // ---------------- round key read port ----------------
    logic [5:0] rk_base;

    always_comb begin
        rk_base = {rk_sel, 2'b00};
        rk_out  = '0;
        if (rk_sel <= 4'(NR)) begin
            rk_out = {w_reg[rk_base], w_reg[rk_base + 6'd1],
                      w_reg[rk_base + 6'd2], w_reg[rk_base + 6'd3]};
        end
    end

    assign busy  = (state_reg == EXPAND);
    assign done  = (state_reg == DONE);
    assign avail = avail_reg;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using FIPS-197 A.1 and all-zero key vectors.
module tb_aes_key_schedule;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic [3:0]   avail;
    logic [3:0]   rk_sel;
    logic [127:0] rk_out;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_Z   = 128'h0;
    localparam logic [127:0] Z_RK1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_key_schedule dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .start  (start),
        .key_in (key_in),
        .busy   (busy),
        .done   (done),
        .avail  (avail),
        .rk_sel (rk_sel),
        .rk_out (rk_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic rk_chk(input string tag, input logic [3:0] sel, input logic [127:0] exp);
        rk_sel = sel;
        #1;
        chk(tag, rk_out, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Start an expansion from IDLE/DONE and follow it to completion, checking
    // timing, avail progression and key outputs. key_in is scrambled while busy.
    task automatic run_key(input string name, input logic [127:0] key, input int pulse_at,
                           input logic [127:0] exp_rk1, input logic [127:0] exp_rk10);
        int cnt;
        key_in = key;
        start  = 1'b1;
        step();
        start  = 1'b0;
        chk({name, "_done_drop"}, {127'd0, done}, 128'd0);
        chk({name, "_busy_on"}, {127'd0, busy}, 128'd1);
        cnt = 0;
        while (!done && cnt < 100) begin
            if (cnt == pulse_at) begin
                start  = 1'b1;
                key_in = '0;
            end
            step();
            start  = 1'b0;
            key_in = {$urandom, $urandom, $urandom, $urandom};
            cnt++;
            if (cnt == 3) chk({name, "_avail_e3"}, {124'd0, avail}, 128'd0);
            if (cnt == 4) begin
                chk({name, "_avail_e4"}, {124'd0, avail}, 128'd1);
                rk_chk({name, "_rk1_early"}, 4'd1, exp_rk1);
            end
            if (cnt == 8) chk({name, "_avail_e8"}, {124'd0, avail}, 128'd2);
            if (cnt == 12) rk_chk({name, "_rk12_busy"}, 4'd12, 128'd0);
        end
        chk({name, "_done_cycles"}, 128'(cnt), 128'd40);
        chk({name, "_avail_end"}, {124'd0, avail}, 128'd10);
        chk({name, "_busy_off"}, {127'd0, busy}, 128'd0);
        rk_chk({name, "_rk0"}, 4'd0, key);
        rk_chk({name, "_rk1"}, 4'd1, exp_rk1);
        rk_chk({name, "_rk10"}, 4'd10, exp_rk10);
        rk_chk({name, "_rk12"}, 4'd12, 128'd0);
        $display("run %s key=%h cycles=%0d rk10=%h", name, key, cnt, rk_out);
    endtask

    initial begin
        RESET  = 1'b1;
        start  = 1'b0;
        key_in = '0;
        rk_sel = 4'd0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_done", {127'd0, done}, 128'd0);
        chk("rst_avail", {124'd0, avail}, 128'd0);
        rk_chk("rst_rk0", 4'd0, 128'd0);
        rk_chk("rst_rk5", 4'd5, 128'd0);
        rk_chk("rst_rk10", 4'd10, 128'd0);
        $display("reset checks done");

        run_key("a1", KEY_A1, -1, A1_RK1, A1_RK10);

        // Restart from DONE with the zero key.
        run_key("zero_restart", KEY_Z, -1, Z_RK1, Z_RK10);

        // Start pulse at cycle 10 of the expansion must be ignored.
        run_key("a1_ignore", KEY_A1, 10, A1_RK1, A1_RK10);

        // Reset mid-expansion clears everything.
        key_in = KEY_A1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        repeat (20) step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("midrst_busy", {127'd0, busy}, 128'd0);
        chk("midrst_done", {127'd0, done}, 128'd0);
        chk("midrst_avail", {124'd0, avail}, 128'd0);
        rk_chk("midrst_rk0", 4'd0, 128'd0);
        rk_chk("midrst_rk1", 4'd1, 128'd0);
        $display("mid-expansion reset checks done");

        run_key("zero_after_rst", KEY_Z, -1, Z_RK1, Z_RK10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
